fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 74 +++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, drives the instruction
// memory address and registers the fetched word into the IF/ID pipeline latch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PC_sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    UPD_HOLD     = 2'd0,
    UPD_REDIRECT = 2'd1,
    UPD_SEQ      = 2'd2
  } upd_e;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  upd_e        upd;

  assign imem_addr      = pc_q;
  // The adder wraps silently at the top of the address space.
  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = branch_target & ~32'h0000_0003;

  // NOTE: every combinational output gets a default first so no latch is
  // inferred on any path through the decision logic.
  always_comb begin
    upd = UPD_SEQ;
    if (stall)       upd = UPD_HOLD;
    else if (PC_sel) upd = UPD_REDIRECT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_pc4   <= 32'd0;
      IF_ID_valid <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (upd)
        UPD_REDIRECT: begin
          // The word fetched this cycle is on the wrong path; squash it.
          pc_q        <= target_aligned;
          IF_ID_instr <= NOP_INSTR;
          IF_ID_pc4   <= 32'd0;
          IF_ID_valid <= 1'b0;
        end
        UPD_SEQ: begin
          pc_q        <= pc_plus4;
          IF_ID_instr <= imem_data;
          IF_ID_pc4   <= pc_plus4;
          IF_ID_valid <= 1'b1;
          if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run compared against a transaction-level model of the fetch pipeline.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, PC_sel;
  logic [31:0] branch_target, imem_data, imem_addr;
  logic [31:0] IF_ID_instr, IF_ID_pc4, fetch_count;
  logic        IF_ID_valid;
  logic [31:0] salt = 32'hA000_0000;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PC_sel(PC_sel),
    .branch_target(branch_target), .imem_data(imem_data),
    .imem_addr(imem_addr), .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4),
    .IF_ID_valid(IF_ID_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational read, contents derived from the address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  always_comb imem_data = imem_word(imem_addr);

  // One clock edge: drive inputs, advance the model, settle for sampling.
  task automatic step(input logic r, input logic s, input logic sel, input logic [31:0] bt);
    logic [31:0] fetched;
    rst = r; stall = s; PC_sel = sel; branch_target = bt;
    @(posedge clk);
    fetched = imem_word(m_pc);
    if (r) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 0; m_valid = 0; m_count = 0;
    end else if (s) begin
      // everything holds
    end else if (sel) begin
      m_pc = {bt[31:2], 2'b00}; m_instr = NOP_INSTR; m_pc4 = 0; m_valid = 0;
    end else begin
      m_instr = fetched; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    end
    #1;
  endtask

  task automatic test_reset;
    step(1, 1, 1, 32'h0000_0400);
    step(1, 1, 1, 32'h0000_0400);
    n_checks++;
    if (imem_addr !== RESET_PC || IF_ID_instr !== NOP_INSTR || IF_ID_pc4 !== 0 ||
        IF_ID_valid !== 0 || fetch_count !== 0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%h instr=%h pc4=%h valid=%b count=%0d, required addr=%h instr=%h pc4=0 valid=0 count=0",
               imem_addr, IF_ID_instr, IF_ID_pc4, IF_ID_valid, fetch_count, RESET_PC, NOP_INSTR);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_instr [3] = '{32'hA000_0000, 32'hA000_0004, 32'hA000_0008};
    logic [31:0] exp_pc4   [3] = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (IF_ID_instr !== exp_instr[i] || IF_ID_pc4 !== exp_pc4[i] || IF_ID_valid !== 1 ||
          fetch_count !== 32'(i + 1)) begin
        n_fail++;
        $display("FAIL seq_fetch_%0d: instr=%h pc4=%h valid=%b count=%0d, required instr=%h pc4=%h valid=1 count=%0d",
                 i, IF_ID_instr, IF_ID_pc4, IF_ID_valid, fetch_count, exp_instr[i], exp_pc4[i], i + 1);
      end
    end
  endtask

  task automatic test_redirect;
    step(0, 0, 0, 0);   // pc reaches 0x10
    n_checks++;
    if (imem_addr !== 32'h10) begin
      n_fail++; $display("FAIL redirect_setup: addr=%h required 00000010", imem_addr);
    end
    step(0, 0, 1, 32'h0000_0103);
    n_checks++;
    if (imem_addr !== 32'h100 || IF_ID_valid !== 0 || IF_ID_instr !== NOP_INSTR || fetch_count !== 4) begin
      n_fail++;
      $display("FAIL redirect_bubble: addr=%h valid=%b instr=%h count=%0d, required addr=00000100 valid=0 instr=%h count=4",
               imem_addr, IF_ID_valid, IF_ID_instr, fetch_count, NOP_INSTR);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (IF_ID_instr !== 32'hA000_0100 || IF_ID_pc4 !== 32'h104 || IF_ID_valid !== 1 || fetch_count !== 5) begin
      n_fail++;
      $display("FAIL redirect_target: instr=%h pc4=%h valid=%b count=%0d, required instr=a0000100 pc4=00000104 valid=1 count=5",
               IF_ID_instr, IF_ID_pc4, IF_ID_valid, fetch_count);
    end
  endtask

  task automatic test_stall;
    logic [31:0] a0, i0, p0, c0;
    logic        v0;
    a0 = imem_addr; i0 = IF_ID_instr; p0 = IF_ID_pc4; v0 = IF_ID_valid; c0 = fetch_count;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, (i == 1), 32'h0000_0800);
      n_checks++;
      if (imem_addr !== a0 || IF_ID_instr !== i0 || IF_ID_pc4 !== p0 || IF_ID_valid !== v0 || fetch_count !== c0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: addr=%h instr=%h pc4=%h valid=%b count=%0d, required addr=%h instr=%h pc4=%h valid=%b count=%0d",
                 i, imem_addr, IF_ID_instr, IF_ID_pc4, IF_ID_valid, fetch_count, a0, i0, p0, v0, c0);
      end
    end
  endtask

  task automatic test_wrap;
    step(0, 0, 1, 32'hFFFF_FFFF);
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_setup: addr=%h required fffffffc", imem_addr);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (imem_addr !== 32'h0 || IF_ID_pc4 !== 32'h0 || IF_ID_valid !== 1 || IF_ID_instr !== 32'h5FFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_fetch: addr=%h pc4=%h valid=%b instr=%h, required addr=00000000 pc4=00000000 valid=1 instr=5ffffffc",
               imem_addr, IF_ID_pc4, IF_ID_valid, IF_ID_instr);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] c0;
    logic [31:0] tgt [2] = '{32'h200, 32'h300};
    c0 = fetch_count;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, tgt[i]);
      n_checks++;
      if (imem_addr !== tgt[i] || IF_ID_valid !== 0 || fetch_count !== c0) begin
        n_fail++;
        $display("FAIL b2b_redirect_%0d: addr=%h valid=%b count=%0d, required addr=%h valid=0 count=%0d",
                 i, imem_addr, IF_ID_valid, fetch_count, tgt[i], c0);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    step(0, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0500);   // reset wins over a pending redirect
    n_checks++;
    if (imem_addr !== RESET_PC || IF_ID_valid !== 0 || fetch_count !== 0) begin
      n_fail++;
      $display("FAIL reset_over_redirect: addr=%h valid=%b count=%0d, required addr=%h valid=0 count=0",
               imem_addr, IF_ID_valid, fetch_count, RESET_PC);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (IF_ID_instr !== (RESET_PC ^ salt) || IF_ID_pc4 !== RESET_PC + 4 || fetch_count !== 1) begin
      n_fail++;
      $display("FAIL first_fetch_after_reset: instr=%h pc4=%h count=%0d, required instr=%h pc4=%h count=1",
               IF_ID_instr, IF_ID_pc4, fetch_count, RESET_PC ^ salt, RESET_PC + 4);
    end
  endtask

  task automatic test_random;
    salt = 32'h5A5A_C3C3;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), $urandom);
      n_checks++;
      if (imem_addr !== m_pc || IF_ID_instr !== m_instr || IF_ID_pc4 !== m_pc4 ||
          IF_ID_valid !== m_valid || fetch_count !== m_count) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: addr=%h instr=%h pc4=%h valid=%b count=%0d, required addr=%h instr=%h pc4=%h valid=%b count=%0d",
                 i, imem_addr, IF_ID_instr, IF_ID_pc4, IF_ID_valid, fetch_count,
                 m_pc, m_instr, m_pc4, m_valid, m_count);
      end
    end
  endtask

  initial begin
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 0; m_valid = 0; m_count = 0;
    rst = 1; stall = 0; PC_sel = 0; branch_target = 0;
    test_reset;
    test_sequential;
    test_redirect;
    test_stall;
    test_wrap;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
